alarm_set_ctrl: RTL and testbench
=================================

Name: alarm_set_ctrl

Overview:
Front-panel controller that sequences the alarm_clock datapath from three single-cycle button pulses. It owns the BCD set buses and the LD_time, LD_alarm, STOP_al and AL_ON strobes that alarm_clock consumes. It provides time/alarm editing with BCD wrap, alarm enable toggling, and snooze, which re-arms the alarm at current time + SNOOZE_MIN.

Parameters:
SNOOZE_MIN, 5, snooze length in minutes; legal range 1..9.

Ports:
clk  in  1  system clock, shared with alarm_clock
reset  in  1  synchronous, active-low; sampled on rising clk
btn_mode  in  1  1-cycle pulse, already synchronized; advances edit state
btn_inc  in  1  1-cycle pulse; increments the field under edit
btn_snooze  in  1  1-cycle pulse; snooze while Alarm is high, otherwise toggles AL_ON
Alarm  in  1  alarm_clock Alarm output
H_out1  in  2  current hour tens (BCD)
H_out0  in  4  current hour units
M_out1  in  3  current minute tens
M_out0  in  4  current minute units
H_in1  out  2  set bus hour tens, registered
H_in0  out  4  set bus hour units, registered
M_in1  out  3  set bus minute tens, registered
M_in0  out  4  set bus minute units, registered
LD_time  out  1  1-cycle load strobe for time
LD_alarm  out  1  1-cycle load strobe for alarm
STOP_al  out  1  1-cycle alarm stop strobe
AL_ON  out  1  alarm enable level
edit_sel  out  2  display hint: 0 none, 1 hours, 2 minutes
edit_alarm  out  1  1 while editing alarm, 0 while editing time

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. All set buses 0, LD_time/LD_alarm/STOP_al 0, AL_ON 1, edit_sel 0, edit_alarm 0. Alarm shadow register = 00:00. Reset overrides everything, including mid-edit; no load is issued.
- States: IDLE, T_HR, T_MIN, T_LOAD, A_HR, A_MIN, A_LOAD, SNZ_STOP, SNZ_LOAD.
- Button priority within one cycle: btn_mode > btn_inc > btn_snooze. Lower-priority pulses in that cycle are dropped.
- IDLE + btn_mode -> T_HR. The edit buffer captures H_out1/H_out0/M_out1/M_out0 on that edge.
- T_HR + mode -> T_MIN. T_MIN + mode -> T_LOAD.
- T_LOAD lasts one cycle: LD_time=1, buses hold the buffer. Then -> A_HR, and the buffer loads from the alarm shadow.
- A_HR + mode -> A_MIN. A_MIN + mode -> A_LOAD.
- A_LOAD lasts one cycle: LD_alarm=1, shadow <= buffer. Then -> IDLE.
- btn_inc in *_HR: hours increment BCD 00..23; 09->10, 19->20, 23->00.
- btn_inc in *_MIN: minutes increment 00..59; 59->00 with no carry into hours.
- btn_inc in IDLE or a LOAD state is ignored.
- btn_snooze in IDLE with Alarm==1 -> SNZ_STOP.
  - SNZ_STOP: STOP_al=1 for one cycle. Buffer <= current time + SNOOZE_MIN minutes, with minute carry into hours and 23:59 wrap to 00:xx.
  - Next cycle SNZ_LOAD: LD_alarm=1 and shadow updated. Then -> IDLE.
- btn_snooze in IDLE with Alarm==0: AL_ON toggles. In any other state btn_snooze is ignored.
- Set buses are driven from the edit buffer in every state. In IDLE they hold their last value.
- Strobes are registered, exactly one cycle wide, and never asserted together.
- edit_sel: 1 in *_HR, 2 in *_MIN, else 0. edit_alarm: 1 in A_HR/A_MIN/A_LOAD.
- Latency:
  - Mode pulse in *_MIN to load strobe: 1 cycle.
  - Snooze pulse to STOP_al: 1 cycle. To LD_alarm: 2 cycles.

Decomposition:
- Shared package alarm_pkg: state encoding constants, BCD limit constants (HR_MAX_T=2, HR_MAX_U=3, MIN_MAX_T=5, DIGIT_MAX=9), and edit_sel codes.
- Sub-module bcd_time_inc: combinational HH:MM plus a 0..9 minute increment, with a carry_to_hour enable. Used both for edit increments (increment 1, carry disabled) and for the snooze add.

Test Plan:
- Reset low for 2 cycles mid-way through T_MIN -> state IDLE, all strobes 0, buses 0, AL_ON=1, no LD_time pulse.
- Time set: clock at 05:02; mode, inc x2, mode, inc x3, mode -> H_in=07, M_in=05, LD_time pulses exactly 1 cycle, edit_alarm=1 next cycle.
- Hour wrap: in T_HR at 22, inc x2 -> 23 then 00. Minute wrap: in T_MIN at 58, inc x2 -> 59 then 00, hours unchanged.
- Alarm set: in A_HR from shadow 00:00, inc x5, mode, inc x3, mode -> LD_alarm pulse with 05:03, then IDLE; re-entering alarm edit shows 05:03.
- Snooze: Alarm=1, time 23:57, SNOOZE_MIN=5, btn_snooze -> STOP_al at +1 cycle, LD_alarm at +2 with buses 00:02.
- Toggle and priority: Alarm=0, btn_snooze -> AL_ON 1->0. btn_mode and btn_snooze in the same cycle in IDLE -> T_HR entered, AL_ON unchanged.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm front-panel controller: FSM states,
// BCD digit limits and edit_sel display codes.
package alarm_pkg;

  typedef enum logic [3:0] {
    IDLE,
    T_HR,
    T_MIN,
    T_LOAD,
    A_HR,
    A_MIN,
    A_LOAD,
    SNZ_STOP,
    SNZ_LOAD
  } state_t;

  localparam logic [1:0] HR_MAX_T  = 2'd2;
  localparam logic [3:0] HR_MAX_U  = 4'd3;
  localparam logic [2:0] MIN_MAX_T = 3'd5;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HR   = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;

endpackage

// File: rtl/bcd_time_inc.sv
// Combinational BCD HH:MM + 0..9 minutes; the minute overflow ripples into
// the hours only when carry_to_hour is set. Hours wrap 23 -> 00.
module bcd_time_inc
  import alarm_pkg::*;
(
  input  logic [1:0] hr1,
  input  logic [3:0] hr0,
  input  logic [2:0] min1,
  input  logic [3:0] min0,
  input  logic [3:0] inc,
  input  logic       carry_to_hour,
  output logic [1:0] sum_hr1,
  output logic [3:0] sum_hr0,
  output logic [2:0] sum_min1,
  output logic [3:0] sum_min0
);

  logic [4:0] m0_sum;
  logic       c0;
  logic       c1;

  always_comb begin
    m0_sum   = {1'b0, min0} + {1'b0, inc};
    c0       = (m0_sum > {1'b0, DIGIT_MAX});
    sum_min0 = c0 ? 4'(m0_sum - 5'd10) : m0_sum[3:0];

    c1       = 1'b0;
    sum_min1 = min1;
    if (c0) begin
      if (min1 >= MIN_MAX_T) begin
        sum_min1 = '0;
        c1       = 1'b1;
      end else begin
        sum_min1 = min1 + 3'd1;
      end
    end

    sum_hr1 = hr1;
    sum_hr0 = hr0;
    if (c1 && carry_to_hour) begin
      if (hr1 == HR_MAX_T && hr0 >= HR_MAX_U) begin
        sum_hr1 = '0;
        sum_hr0 = '0;
      end else if (hr0 >= DIGIT_MAX) begin
        sum_hr1 = hr1 + 2'd1;
        sum_hr0 = '0;
      end else begin
        sum_hr0 = hr0 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Front-panel sequencer for alarm_clock: time/alarm editing, alarm enable
// toggle and snooze re-arm, driven by single-cycle button pulses.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_snooze,
  input  logic       Alarm,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [2:0] M_out1,
  input  logic [3:0] M_out0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [2:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic [1:0] edit_sel,
  output logic       edit_alarm
);

  state_t     state;
  logic [1:0] sh_h1;
  logic [3:0] sh_h0;
  logic [2:0] sh_m1;
  logic [3:0] sh_m0;

  logic [1:0] add_hr1, sum_hr1;
  logic [3:0] add_hr0, sum_hr0;
  logic [2:0] add_min1, sum_min1;
  logic [3:0] add_min0, sum_min0;
  logic [3:0] add_val;
  logic       add_carry;

  // One adder serves all three uses: in IDLE it precomputes the snooze
  // target; in *_HR it sees MM=59 so a +1 minute rolls exactly one hour.
  always_comb begin
    add_hr1   = H_in1;
    add_hr0   = H_in0;
    add_min1  = M_in1;
    add_min0  = M_in0;
    add_val   = 4'd1;
    add_carry = 1'b0;
    case (state)
      IDLE: begin
        add_hr1   = H_out1;
        add_hr0   = H_out0;
        add_min1  = M_out1;
        add_min0  = M_out0;
        add_val   = 4'(SNOOZE_MIN);
        add_carry = 1'b1;
      end
      T_HR, A_HR: begin
        add_min1  = MIN_MAX_T;
        add_min0  = DIGIT_MAX;
        add_carry = 1'b1;
      end
      default: ;
    endcase
  end

  bcd_time_inc u_inc (
    .hr1           (add_hr1),
    .hr0           (add_hr0),
    .min1          (add_min1),
    .min0          (add_min0),
    .inc           (add_val),
    .carry_to_hour (add_carry),
    .sum_hr1       (sum_hr1),
    .sum_hr0       (sum_hr0),
    .sum_min1      (sum_min1),
    .sum_min0      (sum_min0)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      H_in1      <= '0;
      H_in0      <= '0;
      M_in1      <= '0;
      M_in0      <= '0;
      sh_h1      <= '0;
      sh_h0      <= '0;
      sh_m1      <= '0;
      sh_m0      <= '0;
      LD_time    <= 1'b0;
      LD_alarm   <= 1'b0;
      STOP_al    <= 1'b0;
      AL_ON      <= 1'b1;
      edit_sel   <= SEL_NONE;
      edit_alarm <= 1'b0;
    end else begin
      LD_time  <= 1'b0;
      LD_alarm <= 1'b0;
      STOP_al  <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_mode) begin
            state    <= T_HR;
            H_in1    <= H_out1;
            H_in0    <= H_out0;
            M_in1    <= M_out1;
            M_in0    <= M_out0;
            edit_sel <= SEL_HR;
          end else if (btn_inc) begin
            state <= IDLE;
          end else if (btn_snooze) begin
            if (Alarm) begin
              state   <= SNZ_STOP;
              STOP_al <= 1'b1;
              H_in1   <= sum_hr1;
              H_in0   <= sum_hr0;
              M_in1   <= sum_min1;
              M_in0   <= sum_min0;
            end else begin
              AL_ON <= ~AL_ON;
            end
          end
        end
        T_HR, A_HR: begin
          if (btn_mode) begin
            state    <= (state == T_HR) ? T_MIN : A_MIN;
            edit_sel <= SEL_MIN;
          end else if (btn_inc) begin
            H_in1 <= sum_hr1;
            H_in0 <= sum_hr0;
          end
        end
        T_MIN, A_MIN: begin
          if (btn_mode) begin
            edit_sel <= SEL_NONE;
            if (state == T_MIN) begin
              state   <= T_LOAD;
              LD_time <= 1'b1;
            end else begin
              state    <= A_LOAD;
              LD_alarm <= 1'b1;
            end
          end else if (btn_inc) begin
            M_in1 <= sum_min1;
            M_in0 <= sum_min0;
          end
        end
        T_LOAD: begin
          state      <= A_HR;
          H_in1      <= sh_h1;
          H_in0      <= sh_h0;
          M_in1      <= sh_m1;
          M_in0      <= sh_m0;
          edit_sel   <= SEL_HR;
          edit_alarm <= 1'b1;
        end
        SNZ_STOP: begin
          state    <= SNZ_LOAD;
          LD_alarm <= 1'b1;
        end
        A_LOAD, SNZ_LOAD: begin
          state      <= IDLE;
          sh_h1      <= H_in1;
          sh_h0      <= H_in0;
          sh_m1      <= M_in1;
          sh_m0      <= M_in0;
          edit_alarm <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl: vector table for the main edit flow,
// hand sequences for hour/minute wrap, mid-edit reset and snooze.
module tb_alarm_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_snooze, Alarm;
  logic [1:0] H_out1;
  logic [3:0] H_out0;
  logic [2:0] M_out1;
  logic [3:0] M_out0;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [2:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON, edit_alarm;
  logic [1:0] edit_sel;
  logic [19:0] act;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_set_ctrl #(.SNOOZE_MIN(5)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_snooze(btn_snooze), .Alarm(Alarm),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
    .edit_sel(edit_sel), .edit_alarm(edit_alarm)
  );

  assign act = {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
                edit_sel, edit_alarm};

  typedef struct {
    logic        mode;
    logic        inc;
    logic        snz;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Expected output word: HH:MM bus, LD_time, LD_alarm, STOP_al, AL_ON, edit_sel, edit_alarm
  function automatic logic [19:0] mk(int h1, int h0, int m1, int m0, int ldt,
                                     int lda, int stp, int on, int sel, int ea);
    return {2'(h1), 4'(h0), 3'(m1), 4'(m0), 1'(ldt), 1'(lda), 1'(stp), 1'(on),
            2'(sel), 1'(ea)};
  endfunction

  function automatic vec_t v(int md, int in, int sz, logic [19:0] e);
    vec_t r;
    r.mode = 1'(md);
    r.inc  = 1'(in);
    r.snz  = 1'(sz);
    r.exp  = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [19:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic step(input logic md, input logic in, input logic sz);
    @(negedge clk);
    btn_mode   = md;
    btn_inc    = in;
    btn_snooze = sz;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; btn_mode = 0; btn_inc = 0; btn_snooze = 0; Alarm = 0;
    H_out1 = 2'd0; H_out0 = 4'd5; M_out1 = 3'd0; M_out0 = 4'd2;

    // Main edit flow at time 05:02, Alarm low
    tbl.push_back(v(1,0,0, mk(0,5,0,2, 0,0,0,1, 1,0)));
    tbl.push_back(v(0,1,0, mk(0,6,0,2, 0,0,0,1, 1,0)));
    tbl.push_back(v(0,1,0, mk(0,7,0,2, 0,0,0,1, 1,0)));
    tbl.push_back(v(1,0,0, mk(0,7,0,2, 0,0,0,1, 2,0)));
    tbl.push_back(v(0,1,0, mk(0,7,0,3, 0,0,0,1, 2,0)));
    tbl.push_back(v(0,1,0, mk(0,7,0,4, 0,0,0,1, 2,0)));
    tbl.push_back(v(0,1,0, mk(0,7,0,5, 0,0,0,1, 2,0)));
    tbl.push_back(v(1,0,0, mk(0,7,0,5, 1,0,0,1, 0,0)));
    tbl.push_back(v(0,0,0, mk(0,0,0,0, 0,0,0,1, 1,1)));
    for (int h = 1; h <= 5; h++)
      tbl.push_back(v(0,1,0, mk(0,h,0,0, 0,0,0,1, 1,1)));
    tbl.push_back(v(1,0,0, mk(0,5,0,0, 0,0,0,1, 2,1)));
    for (int m = 1; m <= 3; m++)
      tbl.push_back(v(0,1,0, mk(0,5,0,m, 0,0,0,1, 2,1)));
    tbl.push_back(v(1,0,0, mk(0,5,0,3, 0,1,0,1, 0,1)));
    tbl.push_back(v(0,0,0, mk(0,5,0,3, 0,0,0,1, 0,0)));
    tbl.push_back(v(0,1,0, mk(0,5,0,3, 0,0,0,1, 0,0)));
    tbl.push_back(v(0,0,1, mk(0,5,0,3, 0,0,0,0, 0,0)));
    tbl.push_back(v(1,0,1, mk(0,5,0,2, 0,0,0,0, 1,0)));
    tbl.push_back(v(0,0,1, mk(0,5,0,2, 0,0,0,0, 1,0)));
    tbl.push_back(v(1,0,0, mk(0,5,0,2, 0,0,0,0, 2,0)));
    tbl.push_back(v(1,0,0, mk(0,5,0,2, 1,0,0,0, 0,0)));
    tbl.push_back(v(0,0,0, mk(0,5,0,3, 0,0,0,0, 1,1)));
    tbl.push_back(v(1,0,0, mk(0,5,0,3, 0,0,0,0, 2,1)));
    tbl.push_back(v(1,0,0, mk(0,5,0,3, 0,1,0,0, 0,1)));
    tbl.push_back(v(0,0,0, mk(0,5,0,3, 0,0,0,0, 0,0)));
    tbl.push_back(v(0,0,1, mk(0,5,0,3, 0,0,0,1, 0,0)));
    tbl.push_back(v(0,1,1, mk(0,5,0,3, 0,0,0,1, 0,0)));
    tbl.push_back(v(0,0,1, mk(0,5,0,3, 0,0,0,0, 0,0)));

    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    chk("reset_state", mk(0,0,0,0, 0,0,0,1, 0,0));
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].mode, tbl[i].inc, tbl[i].snz);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Hour wrap 19->20 and 23->00, minute wrap 59->00 without hour carry
    H_out1 = 2'd1; H_out0 = 4'd9; M_out1 = 3'd5; M_out0 = 4'd8;
    step(1,0,0); chk("hr_enter",  mk(1,9,5,8, 0,0,0,0, 1,0));
    step(0,1,0); chk("hr_19_20",  mk(2,0,5,8, 0,0,0,0, 1,0));
    step(0,1,0); chk("hr_21",     mk(2,1,5,8, 0,0,0,0, 1,0));
    step(0,1,0); chk("hr_22",     mk(2,2,5,8, 0,0,0,0, 1,0));
    step(0,1,0); chk("hr_23",     mk(2,3,5,8, 0,0,0,0, 1,0));
    step(0,1,0); chk("hr_wrap",   mk(0,0,5,8, 0,0,0,0, 1,0));
    step(1,0,0); chk("min_enter", mk(0,0,5,8, 0,0,0,0, 2,0));
    step(0,1,0); chk("min_59",    mk(0,0,5,9, 0,0,0,0, 2,0));
    step(0,1,0); chk("min_wrap",  mk(0,0,0,0, 0,0,0,0, 2,0));

    // Reset mid T_MIN with a mode pulse pending: no LD_time, AL_ON back to 1
    @(negedge clk);
    reset = 1'b0; btn_mode = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_1", mk(0,0,0,0, 0,0,0,1, 0,0));
    step(0,0,0);
    chk("rst_mid_2", mk(0,0,0,0, 0,0,0,1, 0,0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_1", mk(0,0,0,0, 0,0,0,1, 0,0));
    step(0,0,0);
    chk("rst_after_2", mk(0,0,0,0, 0,0,0,1, 0,0));

    // Snooze at 23:57 with SNOOZE_MIN=5 -> 00:02
    H_out1 = 2'd2; H_out0 = 4'd3; M_out1 = 3'd5; M_out0 = 4'd7; Alarm = 1'b1;
    step(0,0,1); chk("snz_stop", mk(0,0,0,2, 0,0,1,1, 0,0));
    step(0,0,0); chk("snz_load", mk(0,0,0,2, 0,1,0,1, 0,0));
    step(0,0,0); chk("snz_idle", mk(0,0,0,2, 0,0,0,1, 0,0));
    Alarm = 1'b0;
    step(1,0,0); chk("snz_t_hr",  mk(2,3,5,7, 0,0,0,1, 1,0));
    step(1,0,0); chk("snz_t_min", mk(2,3,5,7, 0,0,0,1, 2,0));
    step(1,0,0); chk("snz_t_ld",  mk(2,3,5,7, 1,0,0,1, 0,0));
    step(0,0,0); chk("snz_shadow", mk(0,0,0,2, 0,0,0,1, 1,1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
